// File: rtl/fact_checked_unit.sv
`default_nettype none
// ============================================================================
// Module      : fact_checked_unit
// Description : Iterative n! with range and overflow checking, one multiply/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fact_checked_unit #(
    parameter int N_WIDTH   = 4,
    parameter int OUT_WIDTH = 32,
    parameter int MAX_N     = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [N_WIDTH-1:0]   n,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [OUT_WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [31:0]          c_max_n   = 32'(MAX_N);
    localparam logic [N_WIDTH-1:0]   c_cnt_one = {{(N_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [OUT_WIDTH-1:0] c_acc_one = {{(OUT_WIDTH-1){1'b0}}, 1'b1};

    state_t                       r_state;
    state_t                       w_next;
    logic [N_WIDTH-1:0]           r_cnt;
    logic [OUT_WIDTH-1:0]         r_acc;
    logic [OUT_WIDTH-1:0]         r_result;
    logic                         r_ovf;
    logic                         r_err;
    logic [OUT_WIDTH+N_WIDTH-1:0] w_prod;
    logic                         w_prod_ovf;
    logic                         w_range_err;
    logic                         w_cnt_gt1;

    // Full-width product so any bit above OUT_WIDTH flags overflow.
    assign w_prod      = {{N_WIDTH{1'b0}}, r_acc} * {{OUT_WIDTH{1'b0}}, r_cnt};
    assign w_prod_ovf  = |w_prod[OUT_WIDTH+N_WIDTH-1:OUT_WIDTH];
    assign w_range_err = (32'(n) > c_max_n);
    assign w_cnt_gt1   = (r_cnt > c_cnt_one);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_next = w_range_err ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (!w_cnt_gt1) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= c_acc_one;
            r_ovf    <= 1'b0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        // A range error is final here; the DONE cycle only reports it.
                        r_result <= '0;
                        r_err    <= w_range_err;
                        r_cnt    <= n;
                        r_acc    <= c_acc_one;
                        r_ovf    <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (w_cnt_gt1) begin
                        r_acc <= w_prod[OUT_WIDTH-1:0];
                        r_cnt <= r_cnt - c_cnt_one;
                        if (w_prod_ovf) begin
                            r_ovf <= 1'b1;
                        end
                    end else begin
                        r_result <= r_ovf ? '0 : r_acc;
                        r_err    <= r_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign err    = r_err;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_fact_checked_unit.sv
`default_nettype none
// Testbench for fact_checked_unit: scoreboard of expected result/err/latency
// per request, one task per scenario; second instance uses MAX_N=15.
module tb_fact_checked_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic        go2;
    logic [3:0]  n;
    logic [3:0]  n2;
    logic        busy, done, err;
    logic [31:0] result;
    logic        busy2, done2, err2;
    logic [31:0] result2;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fact_checked_unit #(.N_WIDTH(4), .OUT_WIDTH(32), .MAX_N(12)) dut (
        .clk(clk), .rst(rst), .go(go), .n(n),
        .busy(busy), .done(done), .err(err), .result(result)
    );

    fact_checked_unit #(.N_WIDTH(4), .OUT_WIDTH(32), .MAX_N(15)) dut2 (
        .clk(clk), .rst(rst), .go(go2), .n(n2),
        .busy(busy2), .done(done2), .err(err2), .result(result2)
    );

    function automatic exp_t model(input int v, input int maxn);
        exp_t            e;
        longint unsigned f;
        bit              ov;
        f  = 1;
        ov = 0;
        if (v > maxn) begin
            e.res = 32'd0;
            e.err = 1'b1;
            e.lat = 0;
            return e;
        end
        for (int i = 2; i <= v; i++) begin
            f = f * longint'(i);
            if (f > 64'h0000_0000_FFFF_FFFF) ov = 1;
        end
        e.err = ov;
        e.res = ov ? 32'd0 : f[31:0];
        e.lat = (v <= 1) ? 1 : v;
        return e;
    endfunction

    // Called at #1 after an edge; returns at #1 after the accept edge.
    task automatic start(input int v, input bit sel, input bit push_exp, input int maxn);
        if (sel) begin
            go2 = 1'b1;
            n2  = v[3:0];
        end else begin
            go = 1'b1;
            n  = v[3:0];
        end
        @(posedge clk); #1;
        go  = 1'b0;
        go2 = 1'b0;
        if (push_exp) sb.push_back(model(v, maxn));
    endtask

    task automatic wait_done(input int offset, input bit sel);
        int          cyc;
        logic        d;
        logic [31:0] r;
        logic        e_f;
        exp_t        e;
        cyc = offset;
        d   = sel ? done2 : done;
        while (!d && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            d = sel ? done2 : done;
        end
        e   = sb.pop_front();
        r   = sel ? result2 : result;
        e_f = sel ? err2 : err;
        checks++;
        if (d !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: done=%b required 1", d);
        end else begin
            checks++;
            if (r !== e.res) begin
                errors++;
                $display("FAIL result: got %0d required %0d", r, e.res);
            end
            checks++;
            if (e_f !== e.err) begin
                errors++;
                $display("FAIL err: got %b required %b", e_f, e.err);
            end
            checks++;
            if (cyc !== e.lat) begin
                errors++;
                $display("FAIL latency: got %0d required %0d", cyc, e.lat);
            end
        end
        @(posedge clk); #1;
        d = sel ? done2 : done;
        r = sel ? result2 : result;
        checks++;
        if (d !== 1'b0 || r !== e.res) begin
            errors++;
            $display("FAIL done_pulse_hold: done=%b result=%0d required done=0 result=%0d", d, r, e.res);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; go = 1'b0; go2 = 1'b0; n = '0; n2 = '0;
        #12;
        checks++;
        if ({busy, done, err, result} !== 35'd0 || {busy2, done2, err2, result2} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%b/%b/%0d required 0/0/0/0", busy, done, err, result);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        start(5, 0, 1, 12);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_calc: busy=%b done=%b required 1 0", busy, done);
        end
        wait_done(0, 0);
    endtask

    task automatic test_small;
        for (int v = 0; v <= 1; v++) begin
            start(v, 0, 1, 12);
            wait_done(0, 0);
        end
    endtask

    task automatic test_range;
        start(12, 0, 1, 12); wait_done(0, 0);
        start(13, 0, 1, 12); wait_done(0, 0);
        start(15, 0, 1, 12); wait_done(0, 0);
    endtask

    task automatic test_overflow;
        start(12, 1, 1, 15); wait_done(0, 1);
        start(13, 1, 1, 15); wait_done(0, 1);
    endtask

    task automatic test_ignore_go;
        start(6, 0, 1, 12);
        @(posedge clk); #1;
        @(posedge clk); #1;
        go = 1'b1; n = 4'd3;
        @(posedge clk); #1;
        go = 1'b0;
        @(posedge clk); #1;
        go = 1'b1;
        wait_done(4, 0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done: busy=%b required 0", busy);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL held_go_accept: busy=%b required 1", busy);
        end
        go = 1'b0;
        sb.push_back(model(3, 12));
        wait_done(0, 0);
    endtask

    task automatic test_reset_mid;
        bit seen;
        start(10, 0, 0, 12);
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, result} !== 35'd0) begin
            errors++;
            $display("FAIL async_reset: got %b/%b/%b/%0d required 0/0/0/0", busy, done, err, result);
        end
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL no_done_after_reset: done seen=%b required 0", seen);
        end
        start(4, 0, 1, 12);
        wait_done(0, 0);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_small;
        test_range;
        test_overflow;
        test_ignore_go;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
